// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP controller state encoding, sequencer commands/states
// and the fixed tms head patterns used to reach the Shift states from Run-Test/Idle.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RUN_IDLE   = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_RESET      = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_IR_SCAN  = 2'd1,
        OP_DR_SCAN  = 2'd2,
        OP_RUN_IDLE = 2'd3
    } seq_op_e;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_READY  = 3'd1,
        ST_RESET5 = 3'd2,
        ST_HEAD   = 3'd3,
        ST_SHIFT  = 3'd4,
        ST_TAIL   = 3'd5,
        ST_RUN    = 3'd6,
        ST_DONE   = 3'd7
    } seq_state_e;

    // Head patterns, bit0 launched first: Idle->SelDR->SelIR->CapIR->ShiftIR / Idle->SelDR->CapDR->ShiftDR
    localparam logic [3:0] IR_HEAD = 4'b0011;
    localparam logic [2:0] DR_HEAD = 3'b001;

    localparam int RESET_TMS_ONES = 5;

endpackage

// File: rtl/jtag_shift_reg.sv
// Parallel-load tdi shifter with a registered tdi output, plus a tdo capture register
// whose contents are right-aligned by the loaded length so bits >= len read as 0.
module jtag_shift_reg #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               tck,
    input  logic               trst_n,
    input  logic               load,
    input  logic [MAX_LEN-1:0] load_data,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               shift_en,
    input  logic               tdi_en,
    input  logic               tdo,
    output logic               tdi,
    output logic [MAX_LEN-1:0] cap_data
);

    logic [MAX_LEN-1:0] sr;
    logic [MAX_LEN-1:0] sr_shifted;
    logic [MAX_LEN-1:0] cap;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   align;

    assign sr_shifted = sr >> 1;
    // Captured bits enter at the top; after len shifts bit0 sits at MAX_LEN-len.
    assign align      = LEN_W'(MAX_LEN) - len_q;
    assign cap_data   = cap >> align;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            sr    <= '0;
            cap   <= '0;
            len_q <= '0;
            tdi   <= 1'b0;
        end else begin
            if (load) begin
                sr    <= load_data;
                cap   <= '0;
                len_q <= load_len;
            end else if (shift_en) begin
                sr  <= sr_shifted;
                cap <= {tdo, cap[MAX_LEN-1:1]};
            end
            // Launch the bit for the coming shift cycle, accounting for a shift on this edge.
            tdi <= tdi_en ? (shift_en ? sr_shifted[0] : sr[0]) : 1'b0;
        end
    end

endmodule

// File: rtl/tap_sequencer.sv
// Command-driven JTAG master: walks the TAP from Run-Test/Idle through reset, IR/DR scans
// or idle cycles with registered tms/tdi, and returns the tdo bits captured during shifts.
module tap_sequencer
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               tck,
    input  logic               trst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    input  logic               tdo,
    output logic               tms,
    output logic               tdi,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic [2:0]         seq_state
);

    localparam int CNT_W = LEN_W + 3;

    // Handshake: a command transfers on the posedge where cmd_valid && cmd_ready; cmd_ready is
    // high only in READY, and rsp_valid is a single-cycle pulse in DONE with no back-pressure.

    seq_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    seq_op_e            op_q, op_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               err_q, err_n;
    logic               tms_d;
    logic               accept;
    logic               len_bad;
    logic [CNT_W-1:0]   len_ext;
    logic [CNT_W-1:0]   head_last;
    logic [3:0]         head4;
    logic [MAX_LEN-1:0] cap_data;

    assign accept    = (state == ST_READY) && cmd_valid;
    assign len_bad   = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
    assign len_ext   = CNT_W'(len_q);
    assign head_last = (op_q == OP_IR_SCAN) ? CNT_W'(3) : CNT_W'(2);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        op_n    = op_q;
        len_n   = len_q;
        err_n   = err_q;
        unique case (state)
            ST_INIT: begin
                // cnt==0: the single tms=0 cycle that moves the TAP out of Test-Logic-Reset
                if (cnt != '0) begin
                    state_n = ST_READY;
                    cnt_n   = '0;
                end
            end
            ST_READY: begin
                cnt_n = '0;
                if (cmd_valid) begin
                    op_n  = seq_op_e'(cmd_op);
                    len_n = cmd_len;
                    err_n = (op_n != OP_RESET) && len_bad;
                    if (err_n) begin
                        state_n = ST_DONE;
                    end else begin
                        unique case (op_n)
                            OP_RESET:    state_n = ST_RESET5;
                            OP_IR_SCAN:  state_n = ST_HEAD;
                            OP_DR_SCAN:  state_n = ST_HEAD;
                            OP_RUN_IDLE: state_n = ST_RUN;
                            default:     state_n = ST_DONE;
                        endcase
                    end
                end
            end
            ST_RESET5: begin
                if (cnt == CNT_W'(RESET_TMS_ONES)) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end
            end
            ST_HEAD: begin
                if (cnt == head_last) begin
                    state_n = ST_SHIFT;
                    cnt_n   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt == len_ext - CNT_W'(1)) begin
                    state_n = ST_TAIL;
                    cnt_n   = '0;
                end
            end
            ST_TAIL: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end
            end
            ST_RUN: begin
                if (cnt == len_ext - CNT_W'(1)) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end
            end
            ST_DONE: begin
                state_n = ST_READY;
                cnt_n   = '0;
            end
            default: begin
                state_n = ST_INIT;
                cnt_n   = '0;
            end
        endcase
    end

    // tms for the cycle being entered, so it is launched from a flop on this edge.
    always_comb begin
        head4 = (op_n == OP_IR_SCAN) ? IR_HEAD : {1'b0, DR_HEAD};
        tms_d = 1'b0;
        unique case (state_n)
            ST_RESET5: tms_d = (cnt_n < CNT_W'(RESET_TMS_ONES));
            ST_HEAD:   tms_d = head4[cnt_n[1:0]];
            ST_SHIFT:  tms_d = (cnt_n == CNT_W'(len_n) - CNT_W'(1));
            ST_TAIL:   tms_d = (cnt_n == '0);
            default:   tms_d = 1'b0;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state    <= ST_INIT;
            cnt      <= '0;
            op_q     <= OP_RESET;
            len_q    <= '0;
            err_q    <= 1'b0;
            tms      <= 1'b1;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            len_q <= len_n;
            err_q <= err_n;
            tms   <= tms_d;
            if (state_n == ST_DONE) begin
                rsp_err  <= err_n;
                rsp_data <= (!err_n && (op_n == OP_IR_SCAN || op_n == OP_DR_SCAN)) ? cap_data : '0;
            end
        end
    end

    jtag_shift_reg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shift (
        .tck       (tck),
        .trst_n    (trst_n),
        .load      (accept),
        .load_data (cmd_data),
        .load_len  (cmd_len),
        .shift_en  (state == ST_SHIFT),
        .tdi_en    (state_n == ST_SHIFT),
        .tdo       (tdo),
        .tdi       (tdi),
        .cap_data  (cap_data)
    );

    assign cmd_ready = (state == ST_READY);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state == ST_DONE);
    assign seq_state = state;

endmodule

// File: tb/tb_tap_sequencer.sv
// Directed bench: tap_sequencer driving a behavioural TAP with a 4-bit IR, bypass bit and
// an 8-bit DR (selected by IR=2); stimulus and response are checked against hand-computed values.
module tb_tap_sequencer;
    import jtag_pkg::*;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               tck = 1'b0;
    logic               trst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op = 2'd0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               tdo;
    logic               tms, tdi, cmd_ready, rsp_valid, rsp_err, busy;
    logic [MAX_LEN-1:0] rsp_data;
    logic [2:0]         seq_state;

    int   vectors = 0;
    int   miscompares = 0;
    logic saw_tlr;
    logic saw_rsp;

    always #5 tck = ~tck;

    tap_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .tck       (tck),
        .trst_n    (trst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .tdo       (tdo),
        .tms       (tms),
        .tdi       (tdi),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .seq_state (seq_state)
    );

    // ---------------- TAP controller + IR / bypass / DR model ----------------
    tap_state_e tap_state, tap_next;
    logic [3:0] ir_sr, ir_reg;
    logic [7:0] dr_sr, dr_reg;
    logic       byp;
    logic       dr_sel;
    logic       saw_pause = 1'b0;

    assign dr_sel = (ir_reg == 4'h2);

    always_comb begin
        tap_next = tap_state;
        case (tap_state)
            TAP_RESET:      tap_next = tms ? TAP_RESET     : TAP_RUN_IDLE;
            TAP_RUN_IDLE:   tap_next = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_DR:  tap_next = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   tap_next = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   tap_next = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   tap_next = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   tap_next = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  tap_next = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_IR:  tap_next = tms ? TAP_RESET     : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   tap_next = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   tap_next = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   tap_next = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   tap_next = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  tap_next = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
            default:        tap_next = TAP_RESET;
        endcase
    end

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_state <= TAP_RESET;
            ir_sr     <= 4'h0;
            ir_reg    <= 4'hF;
            dr_sr     <= 8'h00;
            dr_reg    <= 8'h81;
            byp       <= 1'b0;
        end else begin
            tap_state <= tap_next;
            case (tap_state)
                TAP_RESET:      ir_reg <= 4'hF;
                TAP_CAPTURE_IR: ir_sr  <= 4'b0001;
                TAP_SHIFT_IR:   ir_sr  <= {tdi, ir_sr[3:1]};
                TAP_UPDATE_IR:  ir_reg <= ir_sr;
                TAP_CAPTURE_DR: if (dr_sel) dr_sr <= dr_reg; else byp <= 1'b0;
                TAP_SHIFT_DR:   if (dr_sel) dr_sr <= {tdi, dr_sr[7:1]}; else byp <= tdi;
                TAP_UPDATE_DR:  if (dr_sel) dr_reg <= dr_sr;
                TAP_PAUSE_DR, TAP_PAUSE_IR: saw_pause <= 1'b1;
                default: ;
            endcase
        end
    end

    assign tdo = (tap_state == TAP_SHIFT_IR) ? ir_sr[0] :
                 (tap_state == TAP_SHIFT_DR) ? (dr_sel ? dr_sr[0] : byp) : 1'b0;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to its rsp_valid pulse, logging tms/tdi per stimulus cycle.
    task automatic do_cmd(input string tag, input seq_op_e op, input int len,
                          input logic [31:0] data, input int exp_cyc,
                          input logic [63:0] exp_tms, input logic [63:0] exp_tdi,
                          input logic exp_err, input logic [31:0] exp_data);
        int          ncyc;
        logic [63:0] tms_seq;
        logic [63:0] tdi_seq;
        logic        got;
        @(negedge tck);
        chk({tag, ".ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        @(negedge tck);
        cmd_valid = 1'b0;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        got = 1'b0; ncyc = 0; tms_seq = '0; tdi_seq = '0; saw_tlr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (ncyc < 64) begin
                tms_seq[ncyc] = tms;
                tdi_seq[ncyc] = tdi;
            end
            if (tap_state == TAP_RESET) saw_tlr = 1'b1;
            ncyc++;
            @(negedge tck);
        end
        chk({tag, ".rsp_seen"},  64'(got), 64'd1);
        chk({tag, ".cycles"},    64'(ncyc), 64'(exp_cyc));
        chk({tag, ".tms"},       tms_seq, exp_tms);
        chk({tag, ".tdi"},       tdi_seq, exp_tdi);
        chk({tag, ".rsp_err"},   64'(rsp_err), 64'(exp_err));
        chk({tag, ".rsp_data"},  64'(rsp_data), 64'(exp_data));
        chk({tag, ".tms_done"},  64'(tms), 64'd0);
        chk({tag, ".tap_idle"},  64'(tap_state), 64'(TAP_RUN_IDLE));
    endtask

    initial begin
        // Reset values while trst_n is held low
        repeat (2) @(negedge tck);
        chk("rst.tms",       64'(tms), 64'd1);
        chk("rst.tdi",       64'(tdi), 64'd0);
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.rsp_err",   64'(rsp_err), 64'd0);
        chk("rst.rsp_data",  64'(rsp_data), 64'd0);
        chk("rst.state",     64'(seq_state), 64'(ST_INIT));
        chk("rst.tap",       64'(tap_state), 64'(TAP_RESET));
        trst_n = 1'b1;
        @(negedge tck);
        chk("init.tms",       64'(tms), 64'd0);
        chk("init.state",     64'(seq_state), 64'(ST_INIT));
        chk("init.cmd_ready", 64'(cmd_ready), 64'd0);
        chk("init.tap",       64'(tap_state), 64'(TAP_RESET));
        @(negedge tck);
        chk("ready.cmd_ready", 64'(cmd_ready), 64'd1);
        chk("ready.busy",      64'(busy), 64'd0);
        chk("ready.tap",       64'(tap_state), 64'(TAP_RUN_IDLE));

        // IR capture pattern 0001 comes back; IR loads 5 (bypass)
        do_cmd("ir5", OP_IR_SCAN, 4, 32'h5, 10, 64'h183, 64'h50, 1'b0, 32'h1);
        chk("ir5.ir_reg", 64'(ir_reg), 64'h5);
        do_cmd("byp8", OP_DR_SCAN, 8, 32'hA5, 13, 64'hC01, 64'h528, 1'b0, 32'h4A);
        do_cmd("byp3", OP_DR_SCAN, 3, 32'h7, 8, 64'h61, 64'h38, 1'b0, 32'h6);
        // Illegal lengths: no stimulus cycles, rsp_data cleared
        do_cmd("len0", OP_DR_SCAN, 0, 32'hFF, 0, 64'h0, 64'h0, 1'b1, 32'h0);
        do_cmd("len33", OP_RUN_IDLE, MAX_LEN + 1, 32'h0, 0, 64'h0, 64'h0, 1'b1, 32'h0);
        do_cmd("run5", OP_RUN_IDLE, 5, 32'h0, 5, 64'h0, 64'h0, 1'b0, 32'h0);
        // RESET ignores cmd_len, so len=0 is legal here
        do_cmd("reset", OP_RESET, 0, 32'h0, 6, 64'h1F, 64'h0, 1'b0, 32'h0);
        chk("reset.saw_tlr", 64'(saw_tlr), 64'd1);
        chk("reset.ir_reg",  64'(ir_reg), 64'hF);
        // Real DR path: select DR with IR=2, read back its reset contents and write 0x96
        do_cmd("ir2", OP_IR_SCAN, 4, 32'h2, 10, 64'h183, 64'h20, 1'b0, 32'h1);
        do_cmd("dr8", OP_DR_SCAN, 8, 32'h96, 13, 64'hC01, 64'h4B0, 1'b0, 32'h81);
        chk("dr8.dr_reg", 64'(dr_reg), 64'h96);
        // Full-length scan through bypass
        do_cmd("irF", OP_IR_SCAN, 4, 32'hF, 10, 64'h183, 64'hF0, 1'b0, 32'h1);
        do_cmd("byp32", OP_DR_SCAN, MAX_LEN, 32'h8000_0001, 37, 64'hC_0000_0001,
               64'h4_0000_0008, 1'b0, 32'h2);
        @(negedge tck);
        chk("hold.rsp_data",  64'(rsp_data), 64'h2);
        chk("hold.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("hold.cmd_ready", 64'(cmd_ready), 64'd1);

        // Abort at shift cycle 3 of a len=8 DR scan
        cmd_valid = 1'b1;
        cmd_op    = OP_DR_SCAN;
        cmd_len   = LEN_W'(8);
        cmd_data  = 32'hFF;
        @(negedge tck);
        cmd_valid = 1'b0;
        repeat (6) @(negedge tck);
        chk("abort.in_shift", 64'(seq_state), 64'(ST_SHIFT));
        trst_n = 1'b0;
        #1;
        chk("abort.tms",   64'(tms), 64'd1);
        chk("abort.state", 64'(seq_state), 64'(ST_INIT));
        @(negedge tck);
        trst_n  = 1'b1;
        saw_rsp = 1'b0;
        @(negedge tck);
        if (rsp_valid) saw_rsp = 1'b1;
        chk("abort.init_state", 64'(seq_state), 64'(ST_INIT));
        chk("abort.init_tms",   64'(tms), 64'd0);
        @(negedge tck);
        if (rsp_valid) saw_rsp = 1'b1;
        chk("abort.ready",  64'(cmd_ready), 64'd1);
        chk("abort.no_rsp", 64'(saw_rsp), 64'd0);
        do_cmd("post_ir5", OP_IR_SCAN, 4, 32'h5, 10, 64'h183, 64'h50, 1'b0, 32'h1);
        chk("post_ir5.ir_reg", 64'(ir_reg), 64'h5);

        chk("never_paused", 64'(saw_pause), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
